// File: rtl/brnch_next_pc_ctrl.sv
// -----------------------------------------------------------------------------
// brnch_next_pc_ctrl
//
// IF-stage next-PC generator. Holds the fetch PC, a direct-mapped branch
// target buffer (BTB) and a small FIFO of predictions made in IF. When a
// branch resolves in ID, the oldest queued prediction is compared against the
// resolved outcome. On a mispredict, IF/ID is flushed and the PC is
// redirected. The low PC bits index the upstream 2-bit predictor.
//
// Ports:
//   clk                    clock, all state updates on rising edge
//   rst                    synchronous active-high reset
//   stall_if               hold PC and suppress queue push this cycle
//   brch_instr_detectd_IF  instruction at pc_if is a branch
//   prediction             predictor taken/not-taken for pc_if
//   brch_resolve_valid     branch resolved in ID this cycle
//   actual_brch_result     resolved taken
//   actual_brch_target     resolved taken target
//   pc_if                  current fetch PC (registered)
//   branch_addr_lw_5b      pc_if[6:2], predictor index
//   flush_if_id            kill IF/ID contents this cycle
//   q_full_stall           queue full while IF presents a branch
//   resolve_underflow      sticky: resolve seen with empty queue (registered)
// -----------------------------------------------------------------------------
module brnch_next_pc_ctrl #(
  parameter int          BTB_ENTRIES = 16,
  parameter int          QDEPTH      = 2,
  parameter logic [31:0] PC_RESET    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        brch_instr_detectd_IF,
  input  logic        prediction,
  input  logic        brch_resolve_valid,
  input  logic        actual_brch_result,
  input  logic [31:0] actual_brch_target,
  output logic [31:0] pc_if,
  output logic [4:0]  branch_addr_lw_5b,
  output logic        flush_if_id,
  output logic        q_full_stall,
  output logic        resolve_underflow
);

  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = 32 - IDX - 2;
  localparam int QW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  localparam logic [QW:0]   CNT_ZERO = (QW+1)'(0);
  localparam logic [QW:0]   CNT_ONE  = (QW+1)'(1);
  localparam logic [QW:0]   CNT_FULL = (QW+1)'(QDEPTH);
  localparam logic [QW-1:0] PTR_ONE  = QW'(1);

  // State
  logic [31:0]            pc_r;
  logic                   underflow_r;
  logic [BTB_ENTRIES-1:0] btb_valid_r;
  logic [TAGW-1:0]        btb_tag_r [BTB_ENTRIES];
  logic [31:0]            btb_tgt_r [BTB_ENTRIES];
  logic [31:0]            q_pc_r    [QDEPTH];
  logic [31:0]            q_tgt_r   [QDEPTH];
  logic [QDEPTH-1:0]      q_pred_r;
  logic [QW-1:0]          rd_ptr_r;
  logic [QW-1:0]          wr_ptr_r;
  logic [QW:0]            count_r;

  // Combinational
  logic [IDX-1:0] rd_idx_s;
  logic [IDX-1:0] wr_idx_s;
  logic           btb_hit_s;
  logic [31:0]    btb_target_s;
  logic           pred_eff_s;
  logic           pop_s;
  logic           push_s;
  logic           q_full_s;
  logic           q_full_stall_s;
  logic           mispredict_s;
  logic           btb_wr_s;
  logic [31:0]    head_pc_s;
  logic [31:0]    head_tgt_s;
  logic           head_pred_s;
  logic [31:0]    pc_next_s;
  logic [QW:0]    count_next_s;

  // BTB lookup for the current fetch PC and index of the entry being retired
  always_comb begin
    rd_idx_s     = pc_if_idx(pc_r);
    btb_target_s = btb_tgt_r[rd_idx_s];
    btb_hit_s    = btb_valid_r[rd_idx_s] & (btb_tag_r[rd_idx_s] == pc_r[31:IDX+2]);
    head_pc_s    = q_pc_r[rd_ptr_r];
    head_tgt_s   = q_tgt_r[rd_ptr_r];
    head_pred_s  = q_pred_r[rd_ptr_r];
    wr_idx_s     = pc_if_idx(head_pc_s);
  end

  function automatic logic [IDX-1:0] pc_if_idx(input logic [31:0] pc);
    return pc[IDX+1:2];
  endfunction

  // Queue control, mispredict detection and next-PC selection
  always_comb begin
    pop_s          = brch_resolve_valid & (count_r != CNT_ZERO);
    q_full_s       = (count_r == CNT_FULL);
    q_full_stall_s = brch_instr_detectd_IF & q_full_s & ~pop_s;
    pred_eff_s     = brch_instr_detectd_IF & prediction & btb_hit_s;
    // A wrong direction, or right direction (taken) but wrong target
    mispredict_s   = pop_s & ((head_pred_s != actual_brch_result) |
                              (head_pred_s & actual_brch_result &
                               (head_tgt_s != actual_brch_target)));
    // A pop in the same cycle frees a slot, so a full queue may still accept
    push_s         = brch_instr_detectd_IF & ~stall_if & ~mispredict_s &
                     ~(q_full_s & ~pop_s);
    btb_wr_s       = pop_s & actual_brch_result;

    // Mispredict redirect wins over any stall
    if (mispredict_s) begin
      if (actual_brch_result) begin
        pc_next_s = actual_brch_target;
      end else begin
        pc_next_s = head_pc_s + 32'd4;
      end
    end else if (stall_if | q_full_stall_s) begin
      pc_next_s = pc_r;
    end else if (pred_eff_s) begin
      pc_next_s = btb_target_s;
    end else begin
      pc_next_s = pc_r + 32'd4;
    end

    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // PC, queue pointers/count and the sticky underflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r        <= PC_RESET;
      rd_ptr_r    <= QW'(0);
      wr_ptr_r    <= QW'(0);
      count_r     <= CNT_ZERO;
      underflow_r <= 1'b0;
    end else begin
      pc_r <= pc_next_s;
      if (mispredict_s) begin
        // Every younger prediction was made on the wrong path
        count_r  <= CNT_ZERO;
        rd_ptr_r <= wr_ptr_r;
      end else begin
        count_r <= count_next_s;
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
      end
      if (brch_resolve_valid & (count_r == CNT_ZERO)) begin
        underflow_r <= 1'b1;
      end
    end
  end

  // Queue payload storage; contents are only meaningful below count_r
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_pc_r[wr_ptr_r]   <= pc_r;
      q_pred_r[wr_ptr_r] <= pred_eff_s;
      q_tgt_r[wr_ptr_r]  <= btb_target_s;
    end
  end

  // BTB valid bits; only taken resolutions allocate
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid_r <= {BTB_ENTRIES{1'b0}};
    end else if (btb_wr_s) begin
      btb_valid_r[wr_idx_s] <= 1'b1;
    end
  end

  // BTB tag/target payload; same-cycle reads see the old contents
  always_ff @(posedge clk) begin
    if (btb_wr_s) begin
      btb_tag_r[wr_idx_s] <= head_pc_s[31:IDX+2];
      btb_tgt_r[wr_idx_s] <= actual_brch_target;
    end
  end

  assign pc_if             = pc_r;
  assign branch_addr_lw_5b = pc_r[6:2];
  assign flush_if_id       = mispredict_s;
  assign q_full_stall      = q_full_stall_s;
  assign resolve_underflow = underflow_r;

endmodule

// File: tb/tb_brnch_next_pc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_brnch_next_pc_ctrl
//
// Directed stimulus for brnch_next_pc_ctrl. A behavioural model (SV queue for
// in-flight predictions, table of last taken branch per BTB slot) is checked
// against the DUT every cycle. Literal expectations for PC and the flush/stall
// outputs pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_brnch_next_pc_ctrl;

  localparam int NB = 16;
  localparam int QD = 2;

  logic        clk;
  logic        rst;
  logic        stall_if;
  logic        brch_instr_detectd_IF;
  logic        prediction;
  logic        brch_resolve_valid;
  logic        actual_brch_result;
  logic [31:0] actual_brch_target;
  logic [31:0] pc_if;
  logic [4:0]  branch_addr_lw_5b;
  logic        flush_if_id;
  logic        q_full_stall;
  logic        resolve_underflow;

  int n_chk  = 0;
  int n_fail = 0;

  brnch_next_pc_ctrl #(
    .BTB_ENTRIES(NB),
    .QDEPTH     (QD),
    .PC_RESET   (32'h0000_0000)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .stall_if             (stall_if),
    .brch_instr_detectd_IF(brch_instr_detectd_IF),
    .prediction           (prediction),
    .brch_resolve_valid   (brch_resolve_valid),
    .actual_brch_result   (actual_brch_result),
    .actual_brch_target   (actual_brch_target),
    .pc_if                (pc_if),
    .branch_addr_lw_5b    (branch_addr_lw_5b),
    .flush_if_id          (flush_if_id),
    .q_full_stall         (q_full_stall),
    .resolve_underflow    (resolve_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  bit          mb_v  [NB];
  logic [31:0] mb_pc [NB];
  logic [31:0] mb_tg [NB];
  logic [31:0] m_pc;
  bit          m_uf;
  bit          m_ok = 1'b0;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % NB);
  endfunction

  // Model evaluation and comparison, away from the active edge
  always @(negedge clk) begin
    bit          hit, pe, pop, mis, qfs, push;
    logic [31:0] npc, btgt;
    ent_t        h;
    int          s;
    s    = slot(m_pc);
    hit  = mb_v[s] && ((mb_pc[s] >> 6) == (m_pc >> 6));
    btgt = hit ? mb_tg[s] : 32'h0;
    pe   = brch_instr_detectd_IF && prediction && hit;
    pop  = brch_resolve_valid && (mq.size() != 0);
    h    = pop ? mq[0] : '0;
    mis  = pop && ((h.pred != actual_brch_result) ||
                   (h.pred && actual_brch_result && (h.tgt != actual_brch_target)));
    qfs  = brch_instr_detectd_IF && (mq.size() == QD) && !pop;
    push = brch_instr_detectd_IF && !stall_if && !mis && ((mq.size() - int'(pop)) < QD);
    if (m_ok) begin
      chk32("model pc_if", pc_if, m_pc);
      chk32("model branch_addr", {27'd0, branch_addr_lw_5b}, (m_pc >> 2) & 32'h1F);
      chk1("model flush", flush_if_id, mis);
      chk1("model q_full_stall", q_full_stall, qfs);
      chk1("model underflow", resolve_underflow, m_uf);
    end
    if (rst) begin
      m_pc = 32'h0;
      m_uf = 1'b0;
      mq.delete();
      for (int i = 0; i < NB; i++) mb_v[i] = 1'b0;
      m_ok = 1'b1;
    end else if (m_ok) begin
      if (mis)                      npc = actual_brch_result ? actual_brch_target : h.pc + 32'd4;
      else if (stall_if || qfs)     npc = m_pc;
      else if (pe)                  npc = btgt;
      else                          npc = m_pc + 32'd4;
      if (brch_resolve_valid && mq.size() == 0) m_uf = 1'b1;
      if (pop && actual_brch_result) begin
        mb_v[slot(h.pc)]  = 1'b1;
        mb_pc[slot(h.pc)] = h.pc;
        mb_tg[slot(h.pc)] = actual_brch_target;
      end
      if (mis) begin
        mq.delete();
      end else begin
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back('{pc: m_pc, pred: pe, tgt: btgt});
      end
      m_pc = npc;
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  // Apply one cycle of inputs, check combinational outputs, then cross the edge
  task automatic step(input logic s, input logic bi, input logic p, input logic rv,
                      input logic a, input logic [31:0] t, input logic ef, input logic eq);
    stall_if              = s;
    brch_instr_detectd_IF = bi;
    prediction            = p;
    brch_resolve_valid    = rv;
    actual_brch_result    = a;
    actual_brch_target    = t;
    @(negedge clk);
    chk1("flush_if_id", flush_if_id, ef);
    chk1("q_full_stall", q_full_stall, eq);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    stall_if = 1'b0; brch_instr_detectd_IF = 1'b0; prediction = 1'b0;
    brch_resolve_valid = 1'b0; actual_brch_result = 1'b0; actual_brch_target = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and free run
    chk32("reset pc", pc_if, 32'h0);
    chk1("reset underflow", resolve_underflow, 1'b0);
    chk1("reset flush", flush_if_id, 1'b0);
    idle(); chk32("run pc 4", pc_if, 32'h4);
    idle(); chk32("run pc 8", pc_if, 32'h8);
    idle(); chk32("run pc 12", pc_if, 32'hC);
    for (int n = 0; n < 20; n++) begin
      if (pc_if == 32'h40) break;
      idle();
    end
    chk32("reach pc 0x40", pc_if, 32'h40);

    // Predicted taken, BTB empty: falls through, then resolves taken
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk32("btb miss pc", pc_if, 32'h44);
    chk32("pred index 0x44", {27'd0, branch_addr_lw_5b}, 32'd17);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0);
    chk32("redirect 0x100", pc_if, 32'h100);

    // Branch at 0x104 not-taken, resolved taken to 0x40 to get back there
    idle(); chk32("pc 0x104", pc_if, 32'h104);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk32("pc 0x108", pc_if, 32'h108);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 1'b0);
    chk32("redirect 0x40", pc_if, 32'h40);

    // BTB hit at 0x40 and correct resolve
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk32("btb hit pc", pc_if, 32'h100);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
    chk32("correct resolve pc", pc_if, 32'h104);

    // Fill the queue: 0x104 (hit -> 0x40), 0x40 (hit -> 0x100)
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk32("fill 1 pc", pc_if, 32'h40);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk32("fill 2 pc", pc_if, 32'h100);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk32("full hold pc", pc_if, 32'h100);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0);
    chk32("push+pop pc", pc_if, 32'h104);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk32("still full pc", pc_if, 32'h104);

    // Predicted-taken 0x40 resolves not-taken under stall_if
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk32("not-taken redirect", pc_if, 32'h44);

    // Back to 0x40: BTB entry must still point to 0x100
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk32("pc 0x48", pc_if, 32'h48);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 1'b0);
    chk32("redirect 0x40 again", pc_if, 32'h40);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk32("btb unchanged", pc_if, 32'h100);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
    chk32("queue drained pc", pc_if, 32'h104);

    // Resolve with empty queue
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 1'b0);
    chk32("underflow pc", pc_if, 32'h108);
    chk1("underflow set", resolve_underflow, 1'b1);
    idle();
    chk1("underflow sticky", resolve_underflow, 1'b1);

    // PC wrap at 0xFFFF_FFFC
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
    chk32("pc top", pc_if, 32'hFFFF_FFFC);
    idle();
    chk32("pc wrap", pc_if, 32'h0);

    // Reset mid-stream with a mispredict pending
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 1'b0);
    rst = 1'b0;
    chk32("mid reset pc", pc_if, 32'h0);
    chk1("mid reset underflow", resolve_underflow, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
    chk32("post reset pc", pc_if, 32'h4);
    chk1("post reset empty", resolve_underflow, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Bound on total runtime
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d failures", n_chk, n_fail);
    $fatal(1);
  end

endmodule
